pulse_propagation_meter: RTL and testbench
==========================================

Name: pulse_propagation_meter

Overview:
Multi-channel successor to the single-channel restoration timer. It measures, in clk cycles, the delay from a common pulser trigger to the restored pulse on each of NUM_CH channels. Each channel has its own timeout, done/timeout flags and a global completion strobe. It sits between the pulser control logic and the register/telemetry block of the HV carrier.

Parameters:
NUM_CH, 4, number of independent restored-pulse channels (1..16)
CNT_W, 16, per-channel counter width in bits (8..32)
SYNC_STAGES, 2, synchroniser flops on each async input (2..4)
GLITCH_LEN, 3, consecutive high samples required by the optional glitch filter (2..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Pulser_Trigger_Request  in  1  async trigger request, common to all channels; rising edge starts a measurement
Restorated_Pulse  in  NUM_CH  async restored pulse per channel; rising edge stops that channel
Pulser_IC_Error  in  1  synchronous level; aborts all channels while high
Timeout_Limit  in  CNT_W  quasi-static timeout count, sampled every cycle
Pulse_Propagation_Counter  out  NUM_CH*CNT_W  channel i count in bits [i*CNT_W +: CNT_W]
Pulse_Measurement_Done  out  NUM_CH  sticky per-channel valid-measurement flag
Pulse_Timeout  out  NUM_CH  sticky per-channel timeout flag
Measurement_Busy  out  1  high while any channel is in COUNT
All_Done  out  1  one-cycle strobe when the last counting channel finishes

Behaviour:
- Reset: all outputs 0, all synchroniser and edge flops 0, all channels IDLE.
- Input conditioning: each async input passes through SYNC_STAGES flops, then a registered rising-edge detect. Edge latency is SYNC_STAGES+1 clocks.
  - Trigger and pulse paths have identical latency, so the reported count equals the input-to-input delay in clocks.
- Per-channel FSM states: IDLE, COUNT, DONE, TIMEOUT.
- Event priority, evaluated per clock, highest first:
  1. trigger edge: every channel goes to COUNT; counter<=0; Done<=0; Timeout<=0. Applies from any state, including mid-COUNT (restart).
  2. Pulser_IC_Error: every channel goes to IDLE; counter<=0; Done<=0; Timeout<=0. Held high, it keeps all channels in IDLE.
  3. In COUNT with counter==Timeout_Limit: go to TIMEOUT; Pulse_Timeout[i]<=1; counter holds Timeout_Limit with no increment.
  4. In COUNT with restored edge[i]: go to DONE; Pulse_Measurement_Done[i]<=1; counter increments on this clock, then freezes.
  5. In COUNT otherwise: counter<=counter+1.
- Restored edges in IDLE, DONE or TIMEOUT are ignored.
- The counter never wraps, because the timeout check precedes the increment.
- Timeout_Limit=0: the channel reaches TIMEOUT on the first clock after the trigger edge, with count 0.
- Measurement_Busy: combinational OR of (state==COUNT) across all channels.
- All_Done: registered; 1 for exactly one clock when Measurement_Busy falls because of DONE/TIMEOUT transitions.
  - Not asserted when busy falls because of error.
  - Not asserted when busy falls because of reset.
  - A trigger edge that restarts while busy suppresses it.
- Reset asserted mid-measurement: immediate return to reset values; no All_Done afterwards.

Optional Feature:
Macro RESTORE_GLITCH_FILTER_EN.
- Defined: after synchronisation, each Restorated_Pulse bit must be high for GLITCH_LEN consecutive clocks before its rising edge is recognised. Shorter pulses are ignored. Stop latency grows by GLITCH_LEN-1 clocks, so the reported count is input delay + GLITCH_LEN-1.
- Undefined: no filter, edge taken from the synchronised signal directly, GLITCH_LEN unused.
- The trigger path is never filtered.

Test Plan:
1. Defaults, Timeout_Limit=1000; trigger rises, Restorated_Pulse[0..3] rise 100/200/300/400 clocks later -> counts 100/200/300/400, Done=4'hF, Timeout=0, All_Done one pulse 4 clocks after the ch3 pulse rises.
2. Timeout_Limit=50; trigger, no restored pulses -> all counts 50, Timeout=4'hF, Done=0, All_Done one pulse, Busy low.
3. Trigger; Pulser_IC_Error high 1 clock at count 30 -> all counts 0, flags 0, no All_Done; later restored pulses ignored.
4. Trigger; retrigger at count 40; ch0 pulse 25 clocks after retrigger -> ch0 count 25, Done[0]=1, no All_Done between the triggers.
5. Reset pulsed while counting at count 77 -> outputs 0 on the reset edge, stay IDLE after release.
6. With RESTORE_GLITCH_FILTER_EN, GLITCH_LEN=3: 2-clock pulse ignored; 10-clock pulse 100 clocks after trigger -> count 102.

Source files
------------

// File: rtl/pulse_propagation_meter.sv
// pulse_propagation_meter
//   Measures, in clk cycles, the delay from a common pulser trigger to the
//   restored pulse on each of NUM_CH channels. Each channel has its own
//   timeout, sticky done/timeout flags, and there is a global completion
//   strobe.
//
//   Optional build macro: RESTORE_GLITCH_FILTER_EN
//     When defined, each synchronised restored-pulse bit must stay high for
//     GLITCH_LEN consecutive clocks before its rising edge is recognised.
//     Reported counts then grow by GLITCH_LEN-1. The trigger path is never
//     filtered.
//
// Ports
//   clk                       system clock
//   reset                     asynchronous active-high reset
//   Pulser_Trigger_Request    async trigger; a rising edge starts all channels
//   Restorated_Pulse[NUM_CH]  async restored pulses; a rising edge stops one channel
//   Pulser_IC_Error           synchronous level; aborts all channels while high
//   Timeout_Limit[CNT_W]      timeout count, sampled every cycle
//   Pulse_Propagation_Counter channel i count in [i*CNT_W +: CNT_W]
//   Pulse_Measurement_Done    sticky per-channel valid-measurement flag
//   Pulse_Timeout             sticky per-channel timeout flag
//   Measurement_Busy          high while any channel is counting
//   All_Done                  one-cycle strobe when the last counting channel finishes
module pulse_propagation_meter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GLITCH_LEN  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Pulser_Trigger_Request,
  input  logic [NUM_CH-1:0]         Restorated_Pulse,
  input  logic                      Pulser_IC_Error,
  input  logic [CNT_W-1:0]          Timeout_Limit,
  output logic [NUM_CH*CNT_W-1:0]   Pulse_Propagation_Counter,
  output logic [NUM_CH-1:0]         Pulse_Measurement_Done,
  output logic [NUM_CH-1:0]         Pulse_Timeout,
  output logic                      Measurement_Busy,
  output logic                      All_Done
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  // ---------------------------------------------------------------------------
  // Input conditioning: SYNC_STAGES synchroniser flops then a registered
  // rising-edge detect, identical on trigger and pulse paths so the count
  // equals the input-to-input delay.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] trig_sync_q;
  logic                   trig_prev_q;
  logic                   trig_edge_q;
  logic                   trig_lvl;

  logic [NUM_CH-1:0]      pulse_sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]      pulse_lvl;
  logic [NUM_CH-1:0]      pulse_filt;
  logic [NUM_CH-1:0]      pulse_prev_q;
  logic [NUM_CH-1:0]      pulse_edge_q;

  assign trig_lvl  = trig_sync_q[SYNC_STAGES-1];
  assign pulse_lvl = pulse_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_sync_q  <= '0;
      trig_prev_q  <= 1'b0;
      trig_edge_q  <= 1'b0;
      pulse_prev_q <= '0;
      pulse_edge_q <= '0;
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        pulse_sync_q[s] <= '0;
      end
    end else begin
      trig_sync_q     <= {trig_sync_q[SYNC_STAGES-2:0], Pulser_Trigger_Request};
      trig_prev_q     <= trig_lvl;
      trig_edge_q     <= trig_lvl & ~trig_prev_q;
      pulse_sync_q[0] <= Restorated_Pulse;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        pulse_sync_q[s] <= pulse_sync_q[s-1];
      end
      pulse_prev_q    <= pulse_filt;
      pulse_edge_q    <= pulse_filt & ~pulse_prev_q;
    end
  end

`ifdef RESTORE_GLITCH_FILTER_EN
  // run_q counts consecutive high samples already seen (saturating); the
  // filtered level rises on the GLITCH_LEN-th consecutive high sample.
  localparam logic [3:0] RUN_MAX = 4'(GLITCH_LEN - 1);

  logic [3:0] run_q [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        run_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!pulse_lvl[i]) begin
          run_q[i] <= '0;
        end else if (run_q[i] != RUN_MAX) begin
          run_q[i] <= run_q[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    pulse_filt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pulse_filt[i] = pulse_lvl[i] && (run_q[i] == RUN_MAX);
    end
  end
`else
  assign pulse_filt = pulse_lvl;
`endif

  // ---------------------------------------------------------------------------
  // Per-channel measurement FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q [NUM_CH];
  logic [1:0]       state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] tmo_q, tmo_d;
  logic              all_done_q, all_done_d;
  logic              busy, busy_d;

  always_comb begin
    done_d = done_q;
    tmo_d  = tmo_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (trig_edge_q) begin
        state_d[i] = ST_COUNT;
        cnt_d[i]   = '0;
        done_d[i]  = 1'b0;
        tmo_d[i]   = 1'b0;
      end else if (Pulser_IC_Error) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
        done_d[i]  = 1'b0;
        tmo_d[i]   = 1'b0;
      end else if (state_q[i] == ST_COUNT) begin
        // Timeout check precedes the increment, so the counter never wraps.
        if (cnt_q[i] == Timeout_Limit) begin
          state_d[i] = ST_TIMEOUT;
          tmo_d[i]   = 1'b1;
          cnt_d[i]   = Timeout_Limit;
        end else if (pulse_edge_q[i]) begin
          state_d[i] = ST_DONE;
          done_d[i]  = 1'b1;
          cnt_d[i]   = cnt_q[i] + 1'b1;
        end else begin
          cnt_d[i]   = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy   = 1'b0;
    busy_d = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      busy   = busy   | (state_q[i] == ST_COUNT);
      busy_d = busy_d | (state_d[i] == ST_COUNT);
    end
    // Busy falling only counts as completion when no abort caused it.
    all_done_d = busy & ~busy_d & ~trig_edge_q & ~Pulser_IC_Error;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q     <= '0;
      tmo_q      <= '0;
      all_done_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      all_done_q <= all_done_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    Pulse_Propagation_Counter = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      Pulse_Propagation_Counter[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign Pulse_Measurement_Done = done_q;
  assign Pulse_Timeout          = tmo_q;
  assign Measurement_Busy       = busy;
  assign All_Done               = all_done_q;

endmodule

// File: tb/tb_pulse_propagation_meter.sv
// Self-checking bench for pulse_propagation_meter (default parameters).
// Expected per-channel counts and flags are queued when stimulus is driven
// and compared when the design signals completion or at a fixed check point.
module tb_pulse_propagation_meter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    trig;
  logic [NUM_CH-1:0]       rpulse;
  logic                    err;
  logic [CNT_W-1:0]        tlimit;
  logic [NUM_CH*CNT_W-1:0] cnt;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       tmo;
  logic                    busy;
  logic                    all_done;

  int errors = 0;
  int checks = 0;
  int ad_cnt = 0;
  logic [63:0] sb_q[$];

  pulse_propagation_meter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2), .GLITCH_LEN(3)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .Pulser_Trigger_Request    (trig),
    .Restorated_Pulse          (rpulse),
    .Pulser_IC_Error           (err),
    .Timeout_Limit             (tlimit),
    .Pulse_Propagation_Counter (cnt),
    .Pulse_Measurement_Done    (done),
    .Pulse_Timeout             (tmo),
    .Measurement_Busy          (busy),
    .All_Done                  (all_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (all_done) ad_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ch_cnt(input int i);
    return 64'(cnt[i*CNT_W +: CNT_W]);
  endfunction

  task automatic push_exp(input int c0, input int c1, input int c2, input int c3,
                          input int d, input int t);
    sb_q.push_back(64'(c0));
    sb_q.push_back(64'(c1));
    sb_q.push_back(64'(c2));
    sb_q.push_back(64'(c3));
    sb_q.push_back(64'(d));
    sb_q.push_back(64'(t));
  endtask

  task automatic sb_compare(input string tag);
    logic [63:0] e;
    if (sb_q.size() < NUM_CH + 2) begin
      chk({tag, "_sb_depth"}, 64'(sb_q.size()), 64'(NUM_CH + 2));
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        e = sb_q.pop_front();
        chk($sformatf("%s_cnt%0d", tag, i), ch_cnt(i), e);
      end
      e = sb_q.pop_front();
      chk({tag, "_done"}, 64'(done), e);
      e = sb_q.pop_front();
      chk({tag, "_timeout"}, 64'(tmo), e);
    end
  endtask

  task automatic wait_all_done(input string tag, input int bound, output int k);
    k = 0;
    while (!all_done && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_all_done_seen"}, 64'(all_done), 64'd1);
  endtask

  task automatic wait_cnt0(input string tag, input int v, input int bound);
    int k = 0;
    while (ch_cnt(0) != 64'(v) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_reach_cnt"}, ch_cnt(0), 64'(v));
  endtask

  task automatic idle_gap();
    trig   = 1'b0;
    rpulse = '0;
    err    = 1'b0;
    repeat (10) @(negedge clk);
    ad_cnt = 0;
  endtask

  initial begin
    int k;
    reset  = 1'b1;
    trig   = 1'b0;
    rpulse = '0;
    err    = 1'b0;
    tlimit = 16'd1000;
    repeat (3) @(negedge clk);
    push_exp(0, 0, 0, 0, 0, 0);
    sb_compare("reset");
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_all_done", 64'(all_done), 64'd0);
    reset = 1'b0;
    idle_gap();

    // 1: staggered restored pulses
    tlimit = 16'd1000;
    push_exp(100, 200, 300, 400, 4'hF, 0);
    trig = 1'b1;
    for (int d = 1; d <= 400; d++) begin
      @(negedge clk);
      if (d == 100) rpulse[0] = 1'b1;
      if (d == 200) rpulse[1] = 1'b1;
      if (d == 300) rpulse[2] = 1'b1;
      if (d == 400) rpulse[3] = 1'b1;
    end
    wait_all_done("t1", 20, k);
    chk("t1_all_done_latency", 64'(k), 64'd4);
    sb_compare("t1");
    chk("t1_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t1_all_done_width", 64'(all_done), 64'd0);
    chk("t1_all_done_count", 64'(ad_cnt), 64'd1);
    idle_gap();

    // 2: all channels time out
    tlimit = 16'd50;
    push_exp(50, 50, 50, 50, 0, 4'hF);
    trig = 1'b1;
    wait_all_done("t2", 200, k);
    sb_compare("t2");
    chk("t2_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t2_all_done_count", 64'(ad_cnt), 64'd1);
    idle_gap();

    // 3: error aborts mid-count
    tlimit = 16'd1000;
    push_exp(0, 0, 0, 0, 0, 0);
    trig = 1'b1;
    wait_cnt0("t3", 30, 100);
    err = 1'b1;
    @(negedge clk);
    err = 1'b0;
    chk("t3_busy_after_err", 64'(busy), 64'd0);
    rpulse = '1;
    repeat (20) @(negedge clk);
    sb_compare("t3");
    chk("t3_all_done_count", 64'(ad_cnt), 64'd0);
    idle_gap();

    // 4: retrigger restarts the measurement
    tlimit = 16'd200;
    push_exp(25, 200, 200, 200, 4'h1, 4'hE);
    trig = 1'b1;
    repeat (3) @(negedge clk);
    trig = 1'b0;
    wait_cnt0("t4", 40, 100);
    chk("t4_no_all_done_before_retrig", 64'(ad_cnt), 64'd0);
    trig = 1'b1;
    for (int d = 1; d <= 25; d++) @(negedge clk);
    rpulse[0] = 1'b1;
    wait_all_done("t4", 400, k);
    sb_compare("t4");
    @(negedge clk);
    chk("t4_all_done_count", 64'(ad_cnt), 64'd1);
    idle_gap();

    // 5: reset mid-measurement
    tlimit = 16'd1000;
    trig = 1'b1;
    repeat (3) @(negedge clk);
    trig = 1'b0;
    wait_cnt0("t5", 77, 200);
    reset = 1'b1;
    #1;
    push_exp(0, 0, 0, 0, 0, 0);
    sb_compare("t5_in_reset");
    chk("t5_busy_in_reset", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    push_exp(0, 0, 0, 0, 0, 0);
    sb_compare("t5_after");
    chk("t5_busy_after", 64'(busy), 64'd0);
    chk("t5_all_done_count", 64'(ad_cnt), 64'd0);
    idle_gap();

`ifdef RESTORE_GLITCH_FILTER_EN
    // 6: glitch filter rejects a 2-clock pulse, accepts a long one
    tlimit = 16'd1000;
    push_exp(102, 102, 102, 102, 4'hF, 0);
    trig = 1'b1;
    for (int d = 1; d <= 100; d++) begin
      @(negedge clk);
      if (d == 50)  rpulse = '1;
      if (d == 52)  rpulse = '0;
      if (d == 100) rpulse = '1;
    end
    wait_all_done("t6", 20, k);
    sb_compare("t6");
    repeat (4) @(negedge clk);
    rpulse = '0;
    chk("t6_all_done_count", 64'(ad_cnt), 64'd1);
    idle_gap();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
